// File: rtl/cache_block_store.sv
// 32 x 8 single-port cache data store with per-entry written flags.
// Reads win over simultaneous writes; the whole array is exposed for monitors.
module cbs_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             written
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             written_q, written_d;

  always_comb begin
    data_d    = data_q;
    written_d = written_q;
    if (we) begin
      data_d    = wdata;
      written_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      written_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      written_q <= written_d;
    end
  end

  assign data    = data_q;
  assign written = written_q;
endmodule

module cache_block_store #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pr_rd,
  input  logic                   pr_wr,
  input  logic [AW-1:0]          addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   rd_hit,
  output logic                   conflict,
  output logic [DEPTH*WIDTH-1:0] cache_data,
  output logic [DEPTH-1:0]       entry_valid
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            written;
  logic [DEPTH-1:0]            we;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_hit_q, rd_hit_d;
  logic             conflict_q, conflict_d;

  // A write is dropped whenever a read is requested in the same cycle.
  always_comb begin
    we = '0;
    if (pr_wr && !pr_rd) we[addr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    cbs_entry #(.WIDTH(WIDTH)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .we     (we[i]),
      .wdata  (wr_data),
      .data   (mem[i]),
      .written(written[i])
    );
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_hit_d   = rd_hit_q;
    rd_valid_d = pr_rd;
    conflict_d = pr_rd & pr_wr;
    if (pr_rd) begin
      rd_data_d = mem[addr];
      rd_hit_d  = written[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      conflict_q <= conflict_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_hit      = rd_hit_q;
  assign conflict    = conflict_q;
  assign cache_data  = mem;
  assign entry_valid = written;
endmodule

// File: tb/tb_cache_block_store.sv
// Bench for cache_block_store: hand-computed vector table plus a reference
// model feeding a scoreboard queue for the sweeps and reset sequences.
module tb_cache_block_store;
  logic         clk = 1'b0;
  logic         rst;
  logic         pr_rd, pr_wr;
  logic [4:0]   addr;
  logic [7:0]   wr_data;
  logic [7:0]   rd_data;
  logic         rd_valid, rd_hit, conflict;
  logic [255:0] cache_data;
  logic [31:0]  entry_valid;

  cache_block_store dut (
    .clk(clk), .rst(rst), .pr_rd(pr_rd), .pr_wr(pr_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_hit(rd_hit), .conflict(conflict), .cache_data(cache_data),
    .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       hit;
    logic       conf;
  } exp_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] m_mem [32];
  logic       m_val [32];
  logic [7:0] m_data;
  logic       m_hit;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 8'h00;
      m_val[i] = 1'b0;
    end
    m_data = 8'h00;
    m_hit  = 1'b0;
  endtask

  task automatic model(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [7:0] d, output exp_t e);
    if (rd) begin
      m_data = m_mem[a];
      m_hit  = m_val[a];
    end else if (wr) begin
      m_mem[a] = d;
      m_val[a] = 1'b1;
    end
    e = '{valid: rd, data: m_data, hit: m_hit, conf: rd & wr};
  endtask

  // One request cycle: expectation queued at drive time, checked after the edge.
  task automatic step(input string name, input logic rd, input logic wr,
                      input logic [4:0] a, input logic [7:0] d, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    pr_rd = rd; pr_wr = wr; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    pr_rd = 1'b0; pr_wr = 1'b0;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      x = sb.pop_front();
      chk({name, ".rd_valid"}, 256'(rd_valid), 256'(x.valid));
      chk({name, ".conflict"}, 256'(conflict), 256'(x.conf));
      chk({name, ".rd_data"},  256'(rd_data),  256'(x.data));
      chk({name, ".rd_hit"},   256'(rd_hit),   256'(x.hit));
    end
  endtask

  task automatic mstep(input string name, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    model(rd, wr, a, d, e);
    step(name, rd, wr, a, d, e);
  endtask

  vec_t tbl [15];

  initial begin
    exp_t dummy;
    tbl[0]  = '{1'b0, 1'b1, 5'd5, 8'hA5, '{1'b0, 8'h00, 1'b0, 1'b0}};
    tbl[1]  = '{1'b1, 1'b0, 5'd5, 8'h00, '{1'b1, 8'hA5, 1'b1, 1'b0}};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 8'h00, '{1'b0, 8'hA5, 1'b1, 1'b0}};
    tbl[3]  = '{1'b0, 1'b1, 5'd9, 8'h11, '{1'b0, 8'hA5, 1'b1, 1'b0}};
    tbl[4]  = '{1'b1, 1'b1, 5'd9, 8'h77, '{1'b1, 8'h11, 1'b1, 1'b1}};
    tbl[5]  = '{1'b1, 1'b0, 5'd9, 8'h00, '{1'b1, 8'h11, 1'b1, 1'b0}};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 8'h42, '{1'b0, 8'h11, 1'b1, 1'b0}};
    tbl[7]  = '{1'b1, 1'b0, 5'd3, 8'h00, '{1'b1, 8'h42, 1'b1, 1'b0}};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 8'h00, '{1'b0, 8'h42, 1'b1, 1'b0}};
    tbl[9]  = '{1'b0, 1'b0, 5'd0, 8'h00, '{1'b0, 8'h42, 1'b1, 1'b0}};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 8'h00, '{1'b0, 8'h42, 1'b1, 1'b0}};
    tbl[11] = '{1'b1, 1'b0, 5'd7, 8'h00, '{1'b1, 8'h00, 1'b0, 1'b0}};
    tbl[12] = '{1'b0, 1'b1, 5'd7, 8'h5A, '{1'b0, 8'h00, 1'b0, 1'b0}};
    tbl[13] = '{1'b1, 1'b0, 5'd7, 8'h00, '{1'b1, 8'h5A, 1'b1, 1'b0}};
    tbl[14] = '{1'b0, 1'b0, 5'd0, 8'h00, '{1'b0, 8'h5A, 1'b1, 1'b0}};

    rst = 1'b1; pr_rd = 1'b0; pr_wr = 1'b0; addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_data",  256'(rd_data),  256'(0));
    chk("reset.rd_valid", 256'(rd_valid), 256'(0));
    chk("reset.cache",    cache_data,     256'(0));
    chk("reset.valid",    256'(entry_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) mstep("rd_empty", 1'b1, 1'b0, 5'(i), 8'h00);
    chk("empty.cache", cache_data, 256'(0));
    chk("empty.valid", 256'(entry_valid), 256'(0));

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, dummy);
      step($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].e);
    end
    chk("tbl.cache5", 256'(cache_data[47:40]), 256'(8'hA5));
    chk("tbl.cache9", 256'(cache_data[79:72]), 256'(8'h11));
    chk("tbl.valid",  256'(entry_valid), 256'(32'h0000_02A8));

    for (int i = 0; i < 32; i++) mstep("wr_all", 1'b0, 1'b1, 5'(i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < 32; i++) mstep("rd_all", 1'b1, 1'b0, 5'(i), 8'h00);
    chk("all.valid", 256'(entry_valid), 256'(32'hFFFF_FFFF));
    chk("all.cache31", 256'(cache_data[255:248]), 256'(8'h23));

    // Reset mid-cycle while a read result is still presented.
    mstep("pre_rst_rd", 1'b1, 1'b0, 5'd4, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst.rd_valid", 256'(rd_valid), 256'(0));
    chk("arst.rd_data",  256'(rd_data),  256'(0));
    chk("arst.rd_hit",   256'(rd_hit),   256'(0));
    chk("arst.conflict", 256'(conflict), 256'(0));
    chk("arst.cache",    cache_data,     256'(0));
    chk("arst.valid",    256'(entry_valid), 256'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mstep("post_rst_rd", 1'b1, 1'b0, 5'd4, 8'h00);

    chk("sb.drained", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
